// File: rtl/apb_uart_requester.sv
// APB requester for the UART register port.
// Accepts one host command at a time, runs the SETUP/ACCESS sequence and
// returns read data plus a status code. A completion that carries PSLVERR
// is re-issued after an idle back-off, a bounded number of times, so the
// host can poll an empty RX FIFO or a full TX FIFO without stepping in.
// A completer that never raises PREADY is abandoned after TIMEOUT ACCESS
// cycles and reported as a timeout; timeouts are not retried.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// SETUP   | first APB cycle: PSEL=1, PENABLE=0, address/data/dir driven
// ACCESS  | PSEL=1, PENABLE=1; waiting for PREADY or the timeout
// BACKOFF | PSEL=0; idle gap before re-issuing a PSLVERR transfer
// RESP    | response held on rsp_*; waiting for rsp_ready
module apb_uart_requester #(
    parameter int APB_DW    = 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_DW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic [1:0]        rsp_retries,
    output logic [APB_DW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [APB_DW-1:0] PRDATA
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BACKOFF + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BO_LOAD   = BW'(BACKOFF - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_BACKOFF,
        S_RESP
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] bo_cnt;
    logic [RW-1:0] retry_cnt;
    logic          err_flag;
    logic          err_now;
    logic          can_retry;
    logic [1:0]    retries_sat;

    assign cmd_ready = (state == S_IDLE);

    // error seen in this ACCESS cycle or any earlier one of the same attempt
    assign err_now   = err_flag | PSLVERR;
    assign can_retry = (int'(retry_cnt) < MAX_RETRY);

    // retry count as reported to the host, clipped to the 2-bit field
    always_comb begin
        retries_sat = 2'd3;
        if (int'(retry_cnt) <= 3) begin
            retries_sat = 2'(retry_cnt);
        end
    end

    // sequencer: state, counters, APB outputs and the response register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            bo_cnt      <= '0;
            retry_cnt   <= '0;
            err_flag    <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= '0;
            rsp_retries <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        retry_cnt <= '0;
                        wait_cnt  <= '0;
                        err_flag  <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (err_now && can_retry) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            bo_cnt    <= BO_LOAD;
                            state     <= S_BACKOFF;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_status  <= err_now ? ST_SLVERR : ST_OK;
                            rsp_rdata   <= PWRITE ? '0 : PRDATA;
                            rsp_retries <= retries_sat;
                            state       <= S_RESP;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_status  <= ST_TIMEOUT;
                        rsp_rdata   <= '0;
                        rsp_retries <= retries_sat;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                        err_flag <= err_now;
                    end
                end

                S_BACKOFF: begin
                    if (bo_cnt == '0) begin
                        err_flag <= 1'b0;
                        wait_cnt <= '0;
                        PSEL     <= 1'b1;
                        state    <= S_SETUP;
                    end else begin
                        bo_cnt <= bo_cnt - BW'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_requester.sv
// Testbench for apb_uart_requester: directed scenarios followed by random
// commands against a completer driven from per-attempt scripts. The
// expected response, latency and transfer count come from a cycle-budget
// model of the sequence (setup + access cycles per attempt, back-off gaps).
module tb_apb_uart_requester;

    localparam int DW = 8;
    localparam int TO = 16;
    localparam int MR = 3;
    localparam int BO = 8;
    localparam int LIMIT = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [DW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_status;
    logic [1:0]    rsp_retries;
    logic [DW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic          PREADY;
    logic          PSLVERR;
    logic [DW-1:0] PRDATA;

    always #5 clk = ~clk;

    apb_uart_requester #(
        .APB_DW(DW), .TIMEOUT(TO), .MAX_RETRY(MR), .BACKOFF(BO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .rsp_retries(rsp_retries),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    int total = 0;
    int bad   = 0;

    // completer script per attempt: wait states before PREADY, ACCESS-cycle
    // index of a PSLVERR pulse (-1 = none), and PRDATA at completion
    int            w_q [MR+1];
    int            e_q [MR+1];
    logic [DW-1:0] d_q [MR+1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected outcome from the attempt scripts
    task automatic model(input logic wr, output int n_att, output int lat,
                         output logic [1:0] st, output logic [1:0] rt,
                         output logic [DW-1:0] rd);
        int  cyc;
        bit  err;
        cyc   = 1;
        n_att = 0;
        st    = 2'b00;
        rt    = 2'b00;
        rd    = '0;
        for (int a = 0; a <= MR; a++) begin
            n_att++;
            rt = 2'((a > 3) ? 3 : a);
            if (w_q[a] >= TO) begin
                cyc += TO;
                st = 2'b10;
                rd = '0;
                break;
            end
            cyc += w_q[a] + 1;
            err = (e_q[a] >= 0) && (e_q[a] <= w_q[a]);
            rd  = wr ? '0 : d_q[a];
            if (!err) begin
                st = 2'b00;
                break;
            end
            if (a == MR) begin
                st = 2'b01;
                break;
            end
            cyc += BO + 1;
        end
        lat = cyc + 1;
    endtask

    task automatic run_cmd(input string name, input logic wr, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input int hold);
        int            n_att, lat, att, acc, gap, c;
        logic [1:0]    st, rt;
        logic [DW-1:0] rd;
        model(wr, n_att, lat, st, rt, rd);

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        step();
        c   = 1;
        att = -1;
        acc = 0;
        gap = 0;
        while (rsp_valid !== 1'b1 && c < LIMIT) begin
            PREADY    = 1'b0;
            PSLVERR   = 1'b0;
            PRDATA    = DW'($urandom);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = DW'($urandom);
            cmd_wdata = DW'($urandom);
            if (c == 1) chk({name, "_t1_sel_en"}, 32'({PSEL, PENABLE}), 32'b10);
            if (c == 2) chk({name, "_t2_sel_en"}, 32'({PSEL, PENABLE}), 32'b11);
            if (PSEL && !PENABLE) begin
                att++;
                if (att > 0) chk({name, "_backoff_gap"}, 32'(gap), 32'(BO));
                acc = 0;
            end else if (PSEL && PENABLE) begin
                chk({name, "_apb_hold"}, 32'({PWRITE, PADDR, PWDATA}), 32'({wr, addr, wdata}));
                if (att >= 0 && att <= MR) begin
                    PREADY  = (acc == w_q[att]);
                    PSLVERR = (acc == e_q[att]);
                    if (acc == w_q[att]) PRDATA = d_q[att];
                end else begin
                    PREADY = 1'b1;
                end
                acc++;
                gap = 0;
            end else begin
                gap++;
            end
            step();
            c++;
        end
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        cmd_valid = 1'b0;
        chk({name, "_rsp_latency"}, 32'(c), 32'(lat));
        chk({name, "_transfers"}, 32'(att + 1), 32'(n_att));
        chk({name, "_status"}, 32'(rsp_status), 32'(st));
        chk({name, "_retries"}, 32'(rsp_retries), 32'(rt));
        chk({name, "_rdata"}, 32'(rsp_rdata), 32'(rd));
        chk({name, "_sel_idle"}, 32'({PSEL, PENABLE, cmd_ready}), 32'b000);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({name, "_hold_rsp"},
                32'({rsp_valid, rsp_status, rsp_retries, rsp_rdata, PSEL}),
                32'({1'b1, st, rt, rd, 1'b0}));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({name, "_back_idle"}, 32'({rsp_valid, cmd_ready}), 32'b01);
    endtask

    task automatic set_script(input int a, input int w, input int e, input logic [DW-1:0] d);
        w_q[a] = w;
        e_q[a] = e;
        d_q[a] = d;
    endtask

    task automatic clear_script();
        for (int a = 0; a <= MR; a++) set_script(a, 0, -1, '0);
    endtask

    initial begin
        int rsp_seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_status, rsp_retries}), 32'd0);
        chk("reset_apb", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);

        // write, immediate PREADY
        clear_script();
        run_cmd("wr_fast", 1'b1, 8'h02, 8'hA5, 0);

        // read with two wait states
        clear_script();
        set_script(0, 2, -1, 8'h3C);
        run_cmd("rd_wait2", 1'b0, 8'h01, 8'h00, 0);

        // empty-RX poll: two errored completions, then data
        clear_script();
        set_script(0, 0, 0, 8'h11);
        set_script(1, 0, 0, 8'h22);
        set_script(2, 0, -1, 8'h41);
        run_cmd("rx_poll", 1'b0, 8'h02, 8'h00, 1);

        // every completion errors
        clear_script();
        for (int a = 0; a <= MR; a++) set_script(a, 0, 0, DW'(8'h50 + a));
        run_cmd("retry_exh", 1'b0, 8'h02, 8'h00, 0);

        // error flagged in a wait cycle only, completion clean: still an error
        clear_script();
        set_script(0, 2, 1, 8'h77);
        set_script(1, 1, -1, 8'h78);
        run_cmd("sticky_err", 1'b0, 8'h01, 8'h00, 0);

        // no PREADY at all, response held for 5 cycles
        clear_script();
        set_script(0, 1000, -1, 8'hFF);
        run_cmd("timeout", 1'b0, 8'h02, 8'h00, 5);

        // reset on the second ACCESS cycle
        clear_script();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h02;
        cmd_wdata = 8'h5A;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("rst_mid_in_access", 32'({PSEL, PENABLE}), 32'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_apb", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
        chk("rst_mid_rsp", 32'({rsp_valid, rsp_rdata, rsp_status, rsp_retries}), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_seen = 0;
        PREADY   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid === 1'b1 || PSEL === 1'b1) rsp_seen++;
        end
        PREADY = 1'b0;
        chk("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);

        // random commands
        for (int n = 0; n < 30; n++) begin
            for (int a = 0; a <= MR; a++) begin
                int w;
                w = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 4)) :
                                                  int'($urandom_range(0, 3));
                set_script(a, w,
                           ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 4)) - 1,
                           DW'($urandom));
            end
            run_cmd("rand", 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
